// File: rtl/alu_result_fifo.sv
// First-word-fall-through FIFO for ALU results with Z/N/V flag register and saturating overflow counter.
// Optional same-cycle bypass when empty: define ALU_RESULT_FIFO_BYPASS_EN.
module alu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         ALU_out,
  input  logic                     Error,
  input  logic [1:0]               Opcode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_err,
  output logic [1:0]               out_op,
  output logic                     flag_Z,
  output logic                     flag_N,
  output logic                     flag_V,
  output logic [$clog2(DEPTH):0]   count,
  output logic [3:0]               err_cnt,
  input  logic                     err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = WIDTH + 3;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          flag_z_q, flag_z_d, flag_n_q, flag_n_d, flag_v_q, flag_v_d;
  logic [3:0]    err_cnt_q, err_cnt_d;

  logic          empty, full, in_err, push_acc, wr_en, pop, byp, byp_take;
  logic [EW-1:0] entry_in, head, head_sel;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign in_ready = !full;
  // Overflow is only meaningful for arithmetic opcodes (ADD/SUB).
  assign in_err   = Error & ~Opcode[1];
  assign entry_in = {ALU_out, Opcode, in_err};
  assign push_acc = in_valid && in_ready;
  assign head     = mem_q[rd_ptr_q[AW-1:0]];

`ifdef ALU_RESULT_FIFO_BYPASS_EN
  assign byp      = empty && in_valid;
`else
  assign byp      = 1'b0;
`endif
  assign byp_take = byp && out_ready;

  assign out_valid = !empty || byp;
  assign head_sel  = byp ? entry_in : head;
  assign out_data  = out_valid ? head_sel[EW-1:3] : '0;
  assign out_op    = out_valid ? head_sel[2:1]    : '0;
  assign out_err   = out_valid ? head_sel[0]      : 1'b0;

  // A bypassed-and-consumed entry never touches storage or pointers.
  assign wr_en = push_acc && !byp_take;
  assign pop   = !empty && out_ready;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign flag_Z  = flag_z_q;
  assign flag_N  = flag_n_q;
  assign flag_V  = flag_v_q;
  assign err_cnt = err_cnt_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    flag_z_d  = flag_z_q;
    flag_n_d  = flag_n_q;
    flag_v_d  = flag_v_q;
    err_cnt_d = err_cnt_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)   rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push_acc) begin
      flag_z_d = (ALU_out == '0);
      flag_n_d = ALU_out[WIDTH-1];
      if (!Opcode[1]) flag_v_d = Error;
    end
    if (err_clr) begin
      err_cnt_d = 4'd0;
    end else if (push_acc && in_err && (err_cnt_q != 4'hF)) begin
      err_cnt_d = err_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      flag_z_q  <= 1'b0;
      flag_n_q  <= 1'b0;
      flag_v_q  <= 1'b0;
      err_cnt_q <= 4'd0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      flag_z_q  <= flag_z_d;
      flag_n_q  <= flag_n_d;
      flag_v_q  <= flag_v_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Storage needs no reset: entries are only visible between valid pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= entry_in;
  end

endmodule
